// File: rtl/bpf_pipeline_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bpf_pipeline_sequencer_pkg
// Shared control definitions for the pipelined BPF CPU:
//   - sequencer state encodings (SEQ_IDLE..SEQ_DONE)
//   - BPF jump opcode field values and PC select encodings used by stage2
//   - scoreboard / drain timing constants and a load-value helper
// No ports (package).
// -----------------------------------------------------------------------------
package bpf_pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_RUN    = 3'd1,
    SEQ_JWAIT  = 3'd2,
    SEQ_REFILL = 3'd3,
    SEQ_DRAIN  = 3'd4,
    SEQ_DONE   = 3'd5
  } seq_state_t;

  // Jump operation field (bits [7:4] of a BPF_JMP opcode byte).
  localparam logic [7:0] BPF_JA   = 8'h00;
  localparam logic [7:0] BPF_JEQ  = 8'h10;
  localparam logic [7:0] BPF_JGT  = 8'h20;
  localparam logic [7:0] BPF_JGE  = 8'h30;
  localparam logic [7:0] BPF_JSET = 8'h40;

  // Next-PC selection driven by stage2.
  localparam logic [1:0] PC_SEL_NEXT = 2'd0;  // PC + 1
  localparam logic [1:0] PC_SEL_JT   = 2'd1;  // PC + 1 + jt
  localparam logic [1:0] PC_SEL_JF   = 2'd2;  // PC + 1 + jf
  localparam logic [1:0] PC_SEL_K    = 2'd3;  // PC + 1 + k (JA)

  // Cycles between issue of an A/X writer and the register being readable.
  localparam int SB_WB_CYCLES = 2;

  // Minimum residency in DRAIN before DONE may be reported.
  localparam int DRAIN_MIN_CYCLES = 2;

  // Scoreboard load value for an issued writer.
  function automatic int sb_load_cycles(input logic pkt_rd, input int pkt_lat);
    return pkt_rd ? (SB_WB_CYCLES + pkt_lat) : SB_WB_CYCLES;
  endfunction

endpackage

// File: rtl/bpf_pipeline_sequencer_scoreboard_ctr.sv
// -----------------------------------------------------------------------------
// bpf_scoreboard_ctr
// Loadable, saturating down-counter tracking cycles until a pending A or X
// writeback lands. Load has priority over counting; counting stops at zero.
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high (count -> 0)
//   i_en        decrement enable (counter frozen when low)
//   i_load      load i_load_val this cycle
//   i_load_val  value to load
//   o_count     current count
//   o_zero      count is zero (register is safe to read)
// -----------------------------------------------------------------------------
module bpf_scoreboard_ctr
  import bpf_pipeline_sequencer_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/bpf_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// bpf_pipeline_sequencer
// Central sequencer for the pipelined BPF CPU. Runs the start/done handshake,
// produces stall/flush/issue controls for stage0 and stage1, scoreboards
// pending A/X writebacks (no forwarding: a read waits for count 0), holds
// fetch across unresolved jumps and drains the pipeline on RET.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a filter from PC 0 (honoured only in IDLE)
//   done_ack          result consumed (honoured only in DONE)
//   dec_*             stage1 instruction attributes
//   jmp_resolved      stage2 resolved the outstanding jump this cycle
//   stall0, stall1    hold stage0 / hold stage1 (stage2 gets a bubble)
//   flush1            zero stage1 control outputs
//   issue             stage1 instruction advances this cycle
//   busy, done, err   status; err is sticky until rst
// -----------------------------------------------------------------------------
module bpf_pipeline_sequencer
  import bpf_pipeline_sequencer_pkg::*;
#(
  parameter int PKT_RD_LATENCY = 2,
  parameter int REFILL_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done_ack,
  input  logic dec_valid,
  input  logic dec_rd_A,
  input  logic dec_rd_X,
  input  logic dec_wr_A,
  input  logic dec_wr_X,
  input  logic dec_pkt_rd,
  input  logic dec_is_jmp,
  input  logic dec_is_ret,
  input  logic jmp_resolved,
  output logic stall0,
  output logic stall1,
  output logic flush1,
  output logic issue,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int SB_W  = $clog2(PKT_RD_LATENCY + SB_WB_CYCLES + 1);
  localparam int CNT_W = $clog2(REFILL_CYCLES + DRAIN_MIN_CYCLES);

  localparam logic [SB_W-1:0]  SB_LD_ALU = SB_W'(sb_load_cycles(1'b0, PKT_RD_LATENCY));
  localparam logic [SB_W-1:0]  SB_LD_PKT = SB_W'(sb_load_cycles(1'b1, PKT_RD_LATENCY));
  localparam logic [CNT_W-1:0] REFILL_LD = CNT_W'(REFILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_MIN_CYCLES - 1);

  seq_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;     // shared by REFILL and DRAIN
  logic             r_err, w_err_next;

  // Scoreboard lanes: index 0 = A, index 1 = X.
  logic [1:0]      w_rd, w_wr, w_sb_load, w_pend_zero;
  logic [SB_W-1:0] w_pend [2];
  logic            w_sb_en, w_hazard, w_issue;

  assign w_rd    = {dec_rd_X, dec_rd_A};
  assign w_wr    = {dec_wr_X, dec_wr_A};
  assign w_sb_en = (r_state != SEQ_IDLE);
  assign w_issue = issue;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sb
      assign w_sb_load[gi] = w_issue & w_wr[gi];

      bpf_scoreboard_ctr #(
        .W (SB_W)
      ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_sb_en),
        .i_load     (w_sb_load[gi]),
        .i_load_val (dec_pkt_rd ? SB_LD_PKT : SB_LD_ALU),
        .o_count    (w_pend[gi]),
        .o_zero     (w_pend_zero[gi])
      );
    end
  endgenerate

  // Read of a register whose writeback is still in flight.
  assign w_hazard = dec_valid & (|(w_rd & ~w_pend_zero));

  always_comb begin
    stall0       = 1'b1;
    stall1       = 1'b0;
    flush1       = 1'b1;
    issue        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    // A resolve with no jump outstanding is a protocol violation.
    w_err_next   = r_err | (jmp_resolved & (r_state != SEQ_JWAIT));

    case (r_state)
      SEQ_IDLE: begin
        if (start) w_state_next = SEQ_RUN;
      end

      SEQ_RUN: begin
        stall1 = w_hazard;
        stall0 = w_hazard;
        flush1 = 1'b0;
        issue  = dec_valid & ~w_hazard;
        busy   = 1'b1;
        if (issue && dec_is_ret) begin
          // RET dominates; a simultaneous jump flag is malformed decode.
          w_state_next = SEQ_DRAIN;
          w_cnt_next   = DRAIN_LD;
          if (dec_is_jmp) w_err_next = 1'b1;
        end else if (issue && dec_is_jmp) begin
          w_state_next = SEQ_JWAIT;
        end
      end

      SEQ_JWAIT: begin
        busy = 1'b1;
        if (jmp_resolved) begin
          w_state_next = SEQ_REFILL;
          w_cnt_next   = REFILL_LD;
        end
      end

      SEQ_REFILL: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_next = SEQ_RUN;
        else             w_cnt_next   = r_cnt - 1'b1;
      end

      SEQ_DRAIN: begin
        busy = 1'b1;
        if (r_cnt != '0) w_cnt_next = r_cnt - 1'b1;
        if ((r_cnt == '0) && (&w_pend_zero)) w_state_next = SEQ_DONE;
      end

      SEQ_DONE: begin
        done = 1'b1;
        if (done_ack) w_state_next = SEQ_IDLE;
      end

      default: begin
        w_state_next = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_bpf_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bpf_pipeline_sequencer
// Directed bench for bpf_pipeline_sequencer. Each step drives stage1/handshake
// inputs on the falling edge, queues the expected control vector
// {stall0, stall1, flush1, issue, busy, done, err} and compares it against
// the DUT outputs shortly afterwards.
// -----------------------------------------------------------------------------
module tb_bpf_pipeline_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, done_ack = 1'b0, jmp_resolved = 1'b0;
  logic dec_valid = 1'b0, dec_rd_A = 1'b0, dec_rd_X = 1'b0;
  logic dec_wr_A = 1'b0, dec_wr_X = 1'b0, dec_pkt_rd = 1'b0;
  logic dec_is_jmp = 1'b0, dec_is_ret = 1'b0;
  logic stall0, stall1, flush1, issue, busy, done, err;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  bpf_pipeline_sequencer #(
    .PKT_RD_LATENCY (2),
    .REFILL_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done_ack     (done_ack),
    .dec_valid    (dec_valid),
    .dec_rd_A     (dec_rd_A),
    .dec_rd_X     (dec_rd_X),
    .dec_wr_A     (dec_wr_A),
    .dec_wr_X     (dec_wr_X),
    .dec_pkt_rd   (dec_pkt_rd),
    .dec_is_jmp   (dec_is_jmp),
    .dec_is_ret   (dec_is_ret),
    .jmp_resolved (jmp_resolved),
    .stall0       (stall0),
    .stall1       (stall1),
    .flush1       (flush1),
    .issue        (issue),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  function automatic logic [6:0] ex(input logic s0, s1, f1, iss, bsy, dn);
    return {s0, s1, f1, iss, bsy, dn, exp_err};
  endfunction

  task automatic dec(input logic v, ra, rx, wa, wx, pk, jm, rt);
    dec_valid  = v;
    dec_rd_A   = ra;
    dec_rd_X   = rx;
    dec_wr_A   = wa;
    dec_wr_X   = wx;
    dec_pkt_rd = pk;
    dec_is_jmp = jm;
    dec_is_ret = rt;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag, input logic [6:0] e);
    exp_t       item;
    logic [6:0] obs;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
    #2;
    obs  = {stall0, stall1, flush1, issue, busy, done, err};
    item = sb_q.pop_front();
    n_assert++;
    assert (obs === item.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", item.tag, obs, item.exp);
    end
    $display("step %-24s s0 s1 f1 iss busy done err = %b", item.tag, obs);
    @(negedge clk);
  endtask

  task automatic t_idle(input string tag);    step(tag, ex(1, 0, 1, 0, 0, 0)); endtask
  task automatic t_issue(input string tag);   step(tag, ex(0, 0, 0, 1, 1, 0)); endtask
  task automatic t_stall(input string tag);   step(tag, ex(1, 1, 0, 0, 1, 0)); endtask
  task automatic t_runidle(input string tag); step(tag, ex(0, 0, 0, 0, 1, 0)); endtask
  task automatic t_wait(input string tag);    step(tag, ex(1, 0, 1, 0, 1, 0)); endtask
  task automatic t_done(input string tag);    step(tag, ex(1, 0, 1, 0, 0, 1)); endtask

  initial begin
    @(negedge clk);
    t_idle("reset");
    rst = 1'b0;
    t_idle("idle_hold");
    start = 1'b1;
    t_idle("idle_start");
    start = 1'b0;

    // ALU write of A, dependent read waits two cycles.
    dec(1, 0, 0, 1, 0, 0, 0, 0); t_issue("t1_wrA");
    dec(1, 1, 0, 0, 0, 0, 0, 0); t_stall("t1_rdA_stall_p2");
    t_stall("t1_rdA_stall_p1");
    t_issue("t1_rdA_issue");

    // Packet load into X: dependent read waits 2+PKT_RD_LATENCY cycles.
    dec(1, 0, 0, 0, 1, 1, 0, 0); t_issue("t2_pkt_wrX");
    dec(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) t_stall($sformatf("t2_rdX_stall%0d", i));
    t_issue("t2_rdX_issue");
    dec(1, 1, 0, 0, 0, 0, 0, 0); t_issue("t2_rdA_nostall");

    // Jump resolved the cycle after issue: JWAIT, two REFILL, RUN.
    dec(1, 0, 0, 0, 0, 0, 1, 0); t_issue("t3_jmp");
    dec(1, 1, 1, 0, 0, 0, 0, 0); jmp_resolved = 1'b1; t_wait("t3_jwait");
    jmp_resolved = 1'b0;
    t_wait("t3_refill0");
    t_wait("t3_refill1");
    dec(1, 0, 0, 0, 0, 0, 0, 0); t_issue("t3_run");

    // Late resolve: JWAIT holds until jmp_resolved.
    dec(1, 0, 0, 0, 0, 0, 1, 0); t_issue("t3b_jmp");
    dec(0, 0, 0, 0, 0, 0, 0, 0); t_wait("t3b_jwait_hold0");
    t_wait("t3b_jwait_hold1");
    jmp_resolved = 1'b1; t_wait("t3b_resolve");
    jmp_resolved = 1'b0;
    t_wait("t3b_refill0");
    t_wait("t3b_refill1");
    dec(1, 0, 0, 0, 0, 0, 0, 0); t_issue("t3b_run");

    // Stray resolve in RUN: err rises next cycle, state stays RUN.
    dec(0, 0, 0, 0, 0, 0, 0, 0); jmp_resolved = 1'b1; t_runidle("t4_resolve_in_run");
    jmp_resolved = 1'b0; exp_err = 1'b1;
    t_runidle("t4_err_set");
    dec(1, 0, 0, 0, 0, 0, 0, 0); t_issue("t4_still_run");

    // Reset in JWAIT with X pending clears state, counters and err.
    dec(1, 0, 0, 0, 1, 1, 0, 0); t_issue("t5_pkt_wrX");
    dec(1, 0, 0, 0, 0, 0, 1, 0); t_issue("t5_jmp");
    dec(0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1; t_wait("t5_jwait_rst");
    rst = 1'b0; exp_err = 1'b0;
    start = 1'b1; t_idle("t5_after_rst");
    start = 1'b0;
    dec(1, 0, 1, 0, 0, 0, 0, 0); t_issue("t5_pendX_cleared");

    // RET+JMP issued with A pending: DRAIN 2 cycles, err, DONE until ack.
    dec(1, 0, 0, 1, 0, 0, 0, 0); t_issue("t6_wrA");
    dec(1, 0, 0, 0, 0, 0, 1, 1); t_issue("t6_ret_jmp");
    exp_err = 1'b1;
    dec(0, 0, 0, 0, 0, 0, 0, 0); t_wait("t6_drain0");
    t_wait("t6_drain1");
    t_done("t6_done0");
    start = 1'b1; t_done("t6_done1_start_ign");
    start = 1'b0;
    t_done("t6_done2");
    t_done("t6_done3");
    done_ack = 1'b1; t_done("t6_done4_ack");
    done_ack = 1'b0;
    t_idle("t6_idle");
    t_idle("t6_idle_err_sticky");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bpf_pipeline_sequencer.md
Name: bpf_pipeline_sequencer

Overview:
Central sequencer for the pipelined BPF CPU.
- Owns start/done handshake with the packet-filter wrapper.
- Issues per-stage stall/flush controls for stage0 (fetch/PC), stage1 (decode/compute1) and the stage2 input bubble.
- Scoreboards pending A/X writebacks, including packet-memory loads.
- Holds fetch across unresolved jumps and drains the pipeline on RET.

Parameters:
PKT_RD_LATENCY, 2, extra cycles a packet-memory load needs before its A/X writeback completes.
REFILL_CYCLES, 2, cycles stage1 stays flushed after a jump resolves (instruction-memory refill).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin executing a filter from PC 0 (pulse)
done_ack  in  1  consumer has taken the result; return to idle
dec_valid  in  1  stage1 holds a valid instruction
dec_rd_A  in  1  stage1 instruction reads A
dec_rd_X  in  1  stage1 instruction reads X
dec_wr_A  in  1  stage1 instruction writes A
dec_wr_X  in  1  stage1 instruction writes X
dec_pkt_rd  in  1  stage1 instruction is a packet-memory load
dec_is_jmp  in  1  stage1 instruction is any jump (JA/JEQ/JGT/JGE/JSET)
dec_is_ret  in  1  stage1 instruction is RET
jmp_resolved  in  1  stage2 has driven PC_sel/PC_en for the jump this cycle
stall0  out  1  hold PC and fetch register
stall1  out  1  hold stage1 register; stage2 receives a bubble
flush1  out  1  force stage1 control outputs to zero
issue  out  1  stage1 instruction advances to stage2 this cycle
busy  out  1  filter executing
done  out  1  filter finished; held until done_ack
err  out  1  sticky protocol error

Behaviour:
- States: IDLE, RUN, JWAIT, REFILL, DRAIN, DONE. Reset/rst: IDLE, counters 0, err 0.
- Reset priority: rst wins over every other event, including mid-jump and mid-drain.
- Outputs are combinational from state, counters and dec_* inputs.
- In IDLE: stall0=1, flush1=1, stall1=0, issue=0, busy=0, done=0.

- Transitions:
  - IDLE: start -> RUN.
  - RUN: the issued instruction selects the next state.
    - Issued ret -> DRAIN; ret wins if dec_is_ret and dec_is_jmp are both set, and err is set.
    - Otherwise issued jmp -> JWAIT.
  - JWAIT: jmp_resolved -> REFILL; load refill counter with REFILL_CYCLES-1.
  - REFILL: counter reaches 0 -> RUN.
  - DRAIN: move to DONE once pend_A=0, pend_X=0, and at least 2 cycles have passed since entry.
  - DONE: done_ack -> IDLE.

- Output rules:
  - RUN: stall1 = dec_valid & ((dec_rd_A & pend_A≠0) | (dec_rd_X & pend_X≠0)).
  - RUN: stall0 = stall1; issue = dec_valid & ~stall1.
  - JWAIT, REFILL, DRAIN: stall0=1, flush1=1, issue=0, busy=1.
  - DONE: stall0=1, flush1=1, done=1, busy=0.

- Scoreboard (pend_A, pend_X; width clog2(PKT_RD_LATENCY+3)):
  - On issue with wr: load 2, or 2+PKT_RD_LATENCY if dec_pkt_rd.
  - Otherwise decrement when nonzero; saturate at 0.
  - A stage1 read is legal only when the counter is 0; there is no forwarding.
  - Counters keep decrementing in every state except IDLE.
- jmp_resolved outside JWAIT: ignored, err set.
- start outside IDLE: ignored.
- done_ack outside DONE: ignored.
- err clears only on rst.

Decomposition:
- Shared package bpf_ctrl_defs.vh holds:
  - State encodings (SEQ_IDLE..SEQ_DONE).
  - Existing BPF_JA/JEQ/JGT/JGE/JSET and PC_SEL_* constants.
- One natural sub-module, bpf_scoreboard_ctr: a single loadable, saturating down-counter instantiated for A and for X.

Test Plan:
- start, issue wr_A (no pkt_rd), next instr rd_A -> stall1=1 for 2 cycles with pend_A 2→1, then issue=1 on the third cycle.
- PKT_RD_LATENCY=2: pkt load writes X, next instr rd_X -> stall1 held 4 cycles, then issue; rd_A-only instr behind it issues without stall.
- Jump issued at cycle t, jmp_resolved at t+1 -> state JWAIT at t+1, REFILL for 2 cycles (flush1=1, stall0=1), RUN at t+4.
- ret issued with pend_A=2 -> DRAIN 2 cycles, DONE with done=1 held 5 cycles until done_ack, then IDLE, busy=0.
- rst asserted in JWAIT with pend_X=3 -> next cycle IDLE, pend_X=0, stall0=1, flush1=1, err=0.
- jmp_resolved pulsed in RUN -> err=1 and sticky, state unchanged; dec_is_jmp with dec_is_ret issued -> DRAIN, err=1.
